instr_fetch_unit: RTL

Instruction fetch stage for the multi-cycle RV32I core, directly upstream of the control unit. It owns the PC, OLD_PC and IR registers. It issues word fetches to instruction memory over a req/ack handshake and buffers the returned word. It applies the control unit's PC_WE / IR_WE / pcSel decisions and raises `stall` when IR_WE arrives before the instruction word is available.

---
 rtl/core_pkg.sv | 22 ++
 rtl/fetch_buffer.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: data width, the NOP
// encoding used as the IR reset value, and the instruction-fetch FSM states.
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // S_REQ   : a fetch request is outstanding
  // S_FULL  : the fetch buffer holds a valid word, no request outstanding
  // S_DRAIN : a stale request is outstanding; its data will be thrown away
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  // Mask that clears the byte-offset bits of an address.
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

endpackage

// File: rtl/fetch_buffer.sv
// One-word buffer between instruction memory and the IR.
// load_i captures data_i and marks the word valid; clear_i drops the valid
// bit. load_i takes priority if both are asserted.
module fetch_buffer
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o,
  output logic            valid_o
);

  logic [XLEN-1:0] data_q, data_d;
  logic            valid_q, valid_d;

  // Next-state for the buffered word and its valid bit.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC, OLD_PC and IR, issues word fetches to
// instruction memory and applies the control unit's PC_WE / IR_WE / pcSel.
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : a misaligned next PC is refused and sets the sticky
//               'misalign' output (port present).
//   undefined : next PC[1:0] is forced to 00; no 'misalign' port.
//
// Memory handshake: I_MEM_REQ is a valid signal held high with a stable
// I_MEM_ADDR until I_MEM_ACK (the ready/response) is seen high at a rising
// edge; the transfer completes on that edge and I_MEM_DI is sampled there.
// ACK while REQ is low is ignored. REQ drops during RST without waiting for ACK.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] IR_RESET = 32'h0000_0013
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PC_WE,
  input  logic            IR_WE,
  input  logic            pcSel,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alu_out,
  output logic            I_MEM_REQ,
  output logic [XLEN-1:0] I_MEM_ADDR,
  input  logic            I_MEM_ACK,
  input  logic [XLEN-1:0] I_MEM_DI,
  output logic [XLEN-1:0] IR,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] OLD_PC,
  output logic            stall,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic            misalign,
`endif
  output fetch_state_e    dbg_state_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic [XLEN-1:0] ir_q, ir_d;

  logic [XLEN-1:0] next_pc_raw;
  logic [XLEN-1:0] pc_target;
  logic            pc_refused;
  logic            pc_upd;
  logic            ir_load;
  logic            ack_v;
  logic            req;
  logic            buf_load;
  logic            buf_clear;
  logic [XLEN-1:0] buf_data;
  logic            buf_valid;

  fetch_buffer u_fetch_buffer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (I_MEM_DI),
    .data_o  (buf_data),
    .valid_o (buf_valid)
  );

  // Request is state-decoded and suppressed while reset is held.
  assign req   = ~RST & ((state_q == S_REQ) | (state_q == S_DRAIN));
  assign ack_v = I_MEM_ACK & req;
  assign stall = IR_WE & ~buf_valid;

  // Next-PC selection, alignment policy and the effective PC/IR write enables.
  always_comb begin
    next_pc_raw = pcSel ? alu_out : alu_result;
`ifdef IFU_MISALIGN_CHECK_EN
    pc_target  = next_pc_raw;
    pc_refused = PC_WE & ~stall & (next_pc_raw[1:0] != 2'b00);
`else
    pc_target  = next_pc_raw & WORD_MASK;
    pc_refused = 1'b0;
`endif
    // A stalled IR_WE/PC_WE pair is repeated by the control unit, so PC_WE
    // is dropped here rather than queued.
    pc_upd  = PC_WE & ~stall & ~pc_refused;
    ir_load = IR_WE & buf_valid;
  end

  // Fetch FSM: next state, request address and buffer controls.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    case (state_q)
      S_REQ: begin
        if (pc_upd) begin
          // Redirect: data arriving now belongs to the old PC.
          if (ack_v) req_addr_d = pc_target;
          else       state_d    = S_DRAIN;
        end else if (ack_v) begin
          buf_load = 1'b1;
          state_d  = S_FULL;
        end
      end
      S_DRAIN: begin
        if (ack_v) begin
          req_addr_d = pc_upd ? pc_target : pc_q;
          state_d    = S_REQ;
        end
      end
      S_FULL: begin
        if (pc_upd) begin
          buf_clear  = 1'b1;
          req_addr_d = pc_target;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Architectural register next-state: IR/OLD_PC take the old buffer/PC
  // in the same cycle that PC moves on.
  always_comb begin
    pc_d     = pc_q;
    old_pc_d = old_pc_q;
    ir_d     = ir_q;
    if (ir_load) begin
      ir_d     = buf_data;
      old_pc_d = pc_q;
    end
    if (pc_upd) pc_d = pc_target;
  end

  // State and datapath registers; an ACK in the reset cycle is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_REQ;
      req_addr_q <= RESET_PC;
      pc_q       <= RESET_PC;
      old_pc_q   <= RESET_PC;
      ir_q       <= IR_RESET;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      pc_q       <= pc_d;
      old_pc_q   <= old_pc_d;
      ir_q       <= ir_d;
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q;

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST)             misalign_q <= 1'b0;
    else if (pc_refused) misalign_q <= 1'b1;
  end

  assign misalign = misalign_q;
`endif

  assign I_MEM_REQ   = req;
  assign I_MEM_ADDR  = req_addr_q;
  assign IR          = ir_q;
  assign PC          = pc_q;
  assign OLD_PC      = old_pc_q;
  assign dbg_state_o = state_q;

endmodule
